// File: rtl/in_unit8_pkg.sv
// in_unit8_pkg: shared state encoding and entry limits for the decimal entry unit
package in_unit8_pkg;
  typedef enum logic [1:0] {EMPTY, ENTRY, DONE, ERROR} state_t;
  localparam int MAX_DIGITS = 3;
  localparam int MAX_VALUE = 255;
endpackage

// File: rtl/in_unit8_key_debounce.sv
// key_debounce: synchronises and debounces an active-low key, pulsing once per accepted press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic s1_q, s2_q, stable_q, press_q, flip;
  logic [CW-1:0] cnt_q;
  assign flip = (s2_q != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign press_o = press_q;
  // sync, count consecutive differing samples, and register the falling-edge pulse with the flip
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      stable_q <= 1'b1;
      cnt_q <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q <= key_n_i;
      s2_q <= s1_q;
      cnt_q <= (s2_q == stable_q || flip) ? '0 : cnt_q + 1'b1;
      stable_q <= flip ? s2_q : stable_q;
      press_q <= flip && !s2_q;
    end
  end
endmodule

// File: rtl/in_unit8.sv
// in_unit8: debounced key FSM accumulating BCD digits into an 8-bit operand
module in_unit8
  import in_unit8_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       key_enter_n,
  input  logic       key_clear_n,
  input  logic       key_done_n,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       overflow,
  output logic [1:0] digit_count
);
  state_t state_q, state_d;
  logic [7:0] value_q, value_d;
  logic [1:0] count_q, count_d;
  logic ovf_q, ovf_d, valid_q, valid_d;
  logic clr, done, ent, ent_ok, start, append, fits, go_done;
  logic [11:0] v12, sum;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ent (.clock(clock), .reset(reset), .key_n_i(key_enter_n), .press_o(ent));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (.clock(clock), .reset(reset), .key_n_i(key_clear_n), .press_o(clr));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_done (.clock(clock), .reset(reset), .key_n_i(key_done_n), .press_o(done));
  assign v12 = {4'b0, value_q};
  assign sum = (v12 << 3) + (v12 << 1) + {8'b0, digit};
  assign ent_ok = ent && digit <= 4'd9;
  assign start = ent_ok && (state_q == EMPTY || state_q == DONE);
  assign append = ent_ok && state_q == ENTRY && count_q != 2'(MAX_DIGITS);
  assign fits = sum <= 12'(MAX_VALUE);
  assign go_done = done && state_q == ENTRY;
  // state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= EMPTY;
    else state_q <= state_d;
  end
  // next state: clear beats done beats enter; losers are dropped
  always_comb begin
    state_d = clr ? EMPTY :
              done ? (go_done ? DONE : state_q) :
              start ? ENTRY :
              (append && !fits) ? ERROR : state_q;
  end
  // next values of the registered outputs
  always_comb begin
    value_d = clr ? 8'd0 : done ? value_q : start ? {4'b0, digit} : (append && fits) ? sum[7:0] : value_q;
    count_d = clr ? 2'd0 : done ? count_q : start ? 2'd1 : (append && fits) ? count_q + 2'd1 : count_q;
    ovf_d = clr ? 1'b0 : (!done && append && !fits) ? 1'b1 : ovf_q;
    valid_d = !clr && go_done;
  end
  // output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      valid_q <= valid_d;
    end
  end
  assign value = value_q;
  assign digit_count = count_q;
  assign overflow = ovf_q;
  assign value_valid = valid_q;
endmodule

// File: tb/tb_in_unit8.sv
// tb_in_unit8: directed table-driven checks of the decimal entry unit
module tb_in_unit8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] digit = 4'd0;
  logic key_enter_n = 1'b1, key_clear_n = 1'b1, key_done_n = 1'b1;
  logic [7:0] value;
  logic value_valid, overflow;
  logic [1:0] digit_count;
  int n_checks = 0, n_fail = 0, vcnt = 0, ecnt = 0;

  typedef struct {
    logic [2:0] keys;
    logic [3:0] dig;
    int v;
    int c;
    int o;
    int p;
  } vec_t;
  vec_t tv[30];

  in_unit8 #(.DEBOUNCE_CYCLES(4)) dut (
    .clock(clk), .reset(reset), .digit(digit),
    .key_enter_n(key_enter_n), .key_clear_n(key_clear_n), .key_done_n(key_done_n),
    .value(value), .value_valid(value_valid), .overflow(overflow), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (value_valid) vcnt++;
    if (dut.u_ent.press_o) ecnt++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t t);
    vcnt = 0;
    digit = t.dig;
    key_clear_n = ~t.keys[2];
    key_done_n = ~t.keys[1];
    key_enter_n = ~t.keys[0];
    tick(10);
    key_clear_n = 1'b1;
    key_done_n = 1'b1;
    key_enter_n = 1'b1;
    tick(10);
    check($sformatf("vec%0d value", idx), int'(value), t.v);
    check($sformatf("vec%0d count", idx), int'(digit_count), t.c);
    check($sformatf("vec%0d overflow", idx), int'(overflow), t.o);
    check($sformatf("vec%0d valid_cycles", idx), vcnt, t.p);
  endtask

  initial begin
    int lat;
    tv[0]  = '{3'b001, 4'd2, 2, 1, 0, 0};
    tv[1]  = '{3'b001, 4'd5, 25, 2, 0, 0};
    tv[2]  = '{3'b001, 4'd5, 255, 3, 0, 0};
    tv[3]  = '{3'b010, 4'd0, 255, 3, 0, 1};
    tv[4]  = '{3'b010, 4'd0, 255, 3, 0, 0};
    tv[5]  = '{3'b001, 4'd2, 2, 1, 0, 0};
    tv[6]  = '{3'b001, 4'd5, 25, 2, 0, 0};
    tv[7]  = '{3'b001, 4'd6, 25, 2, 1, 0};
    tv[8]  = '{3'b010, 4'd0, 25, 2, 1, 0};
    tv[9]  = '{3'b001, 4'd3, 25, 2, 1, 0};
    tv[10] = '{3'b100, 4'd0, 0, 0, 0, 0};
    tv[11] = '{3'b001, 4'hC, 0, 0, 0, 0};
    tv[12] = '{3'b001, 4'd1, 1, 1, 0, 0};
    tv[13] = '{3'b001, 4'd2, 12, 2, 0, 0};
    tv[14] = '{3'b001, 4'hC, 12, 2, 0, 0};
    tv[15] = '{3'b001, 4'd3, 123, 3, 0, 0};
    tv[16] = '{3'b001, 4'd4, 123, 3, 0, 0};
    tv[17] = '{3'b010, 4'd0, 123, 3, 0, 1};
    tv[18] = '{3'b101, 4'd7, 0, 0, 0, 0};
    tv[19] = '{3'b001, 4'd1, 1, 1, 0, 0};
    tv[20] = '{3'b001, 4'd2, 12, 2, 0, 0};
    tv[21] = '{3'b011, 4'd7, 12, 2, 0, 1};
    tv[22] = '{3'b001, 4'd9, 9, 1, 0, 0};
    tv[23] = '{3'b100, 4'd0, 0, 0, 0, 0};
    tv[24] = '{3'b010, 4'd0, 0, 0, 0, 0};
    tv[25] = '{3'b001, 4'd0, 0, 1, 0, 0};
    tv[26] = '{3'b001, 4'd0, 0, 2, 0, 0};
    tv[27] = '{3'b001, 4'd7, 7, 3, 0, 0};
    tv[28] = '{3'b001, 4'd1, 7, 3, 0, 0};
    tv[29] = '{3'b100, 4'd0, 0, 0, 0, 0};

    tick(3);
    reset = 1'b0;
    check("reset value", int'(value), 0);
    check("reset count", int'(digit_count), 0);
    check("reset overflow", int'(overflow), 0);
    check("reset valid", int'(value_valid), 0);
    tick(5);

    for (int i = 0; i < 30; i++) apply(i, tv[i]);

    // bounce: three short lows then a held low; one event, 6 cycles after the last fall
    digit = 4'd6;
    ecnt = 0;
    for (int k = 0; k < 3; k++) begin
      key_enter_n = 1'b0;
      tick(2);
      key_enter_n = 1'b1;
      tick(2);
    end
    key_enter_n = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (lat < 0 && dut.u_ent.press_o) lat = i;
    end
    key_enter_n = 1'b1;
    tick(10);
    check("bounce latency", lat, 6);
    check("bounce events", ecnt, 1);
    check("bounce value", int'(value), 6);
    check("bounce count", int'(digit_count), 1);

    // reset mid-entry with a key held through reset
    apply(30, '{3'b100, 4'd0, 0, 0, 0, 0});
    apply(31, '{3'b001, 4'd4, 4, 1, 0, 0});
    apply(32, '{3'b001, 4'd2, 42, 2, 0, 0});
    digit = 4'd3;
    key_enter_n = 1'b0;
    tick(3);
    ecnt = 0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst value", int'(value), 0);
    check("rst count", int'(digit_count), 0);
    check("rst overflow", int'(overflow), 0);
    check("rst valid", int'(value_valid), 0);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (lat < 0 && dut.u_ent.press_o) lat = i;
    end
    check("held key latency", lat, 6);
    check("held key events", ecnt, 1);
    check("held key value", int'(value), 3);
    check("held key count", int'(digit_count), 1);
    key_enter_n = 1'b1;
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/in_unit8.md
# in_unit8

Decimal entry unit for the 8-bit calculator: the input-side counterpart to the 8-bit output/display unit. It debounces three active-low pushbuttons and accumulates digits set on four switches into an unsigned 8-bit operand (0–255), entered most-significant digit first. Its value output drives the display unit directly, and a one-cycle valid pulse hands the finished operand to the calculator datapath.

## Interface
- DEBOUNCE_CYCLES, 250000, consecutive stable samples required before a key change is accepted (5 ms at 50 MHz; minimum 2)
- clock  input  1  system clock; the only clock
- reset  input  1  synchronous, active-high
- digit  input  4  BCD digit from the switches; sampled on the cycle the enter event is processed
- key_enter_n  input  1  raw pushbutton, active-low; appends digit
- key_clear_n  input  1  raw pushbutton, active-low; clears entry
- key_done_n  input  1  raw pushbutton, active-low; completes entry
- value  output  8  current accumulated operand
- value_valid  output  1  one-cycle pulse; value is final
- overflow  output  1  sticky flag: last append would exceed 255
- digit_count  output  2  digits accepted so far, 0–3

## Operation
- Each key passes through a 2-flop synchronizer and then a debouncer.
- Debouncer state: stable (reset 1) and counter cnt.
  - Sample == stable: cnt ← 0.
  - Sample != stable and cnt == DEBOUNCE_CYCLES-1: stable ← sample, cnt ← 0.
  - Otherwise cnt increments.
- A press event is a registered one-cycle pulse on the stable 1→0 transition. Releases generate no event.
- States: EMPTY, ENTRY, DONE, ERROR. Reset enters EMPTY.
- Priority when events coincide in one cycle: clear > done > enter. Lower-priority events in that cycle are dropped, not queued.
- clear, any state: value ← 0, digit_count ← 0, overflow ← 0, go to EMPTY.
- enter with digit > 9: ignored in every state; no register changes.
- enter in EMPTY or DONE: value ← digit, digit_count ← 1, go to ENTRY.
- enter in ENTRY:
  - digit_count == 3: ignored.
  - Otherwise compute sum = value*10 + digit at 12-bit width.
  - sum > 255: overflow ← 1, value unchanged, go to ERROR.
  - sum ≤ 255: value ← sum[7:0], digit_count++.
- enter in ERROR: ignored.
- done in ENTRY: value_valid pulses for one cycle, go to DONE. value holds until the next enter or clear.
- done in EMPTY, DONE or ERROR: ignored. No pulse.
- Leading zeros are accepted and count as digits. Example: 0,0,7 gives value 7, digit_count 3.

## Timing
- Reset values: value 0, value_valid 0, overflow 0, digit_count 0, state EMPTY. All synchronizer flops and stable bits reset to 1 (keys released).
- Reset asserted mid-debounce or mid-entry discards everything. No event is generated from a key already held low when reset is released until it has been stable low for DEBOUNCE_CYCLES cycles.
- Latency, raw key falling to press pulse: 2 + DEBOUNCE_CYCLES cycles.
- value, digit_count, overflow and state update on the edge after the press pulse.
- value_valid is asserted in the cycle after the done pulse, for exactly one cycle.
- A bounce shorter than DEBOUNCE_CYCLES consecutive samples produces no event.
- Holding a key produces exactly one event. There is no auto-repeat.
- All outputs are registered.

## Structure
- Package in_unit8_pkg:
  - state enum (EMPTY, ENTRY, DONE, ERROR)
  - MAX_DIGITS = 3
  - MAX_VALUE = 255
- Sub-module key_debounce:
  - contains synchronizer, debouncer and falling-edge pulse
  - parameter DEBOUNCE_CYCLES
  - instantiated three times
- in_unit8 holds the FSM and the multiply-accumulate logic. Implement ×10 as (v<<3)+(v<<1).

## Test plan
Use DEBOUNCE_CYCLES = 4.
- Clean entry: digits 2, 5, 5, then done → value 255, digit_count 3, one value_valid pulse, overflow 0.
- Overflow: digits 2, 5, 6 → after the third enter, overflow 1, value 25, state ERROR. A following done gives no value_valid. A following clear gives value 0, overflow 0.
- Bounce: key_enter_n toggles low/high three times at 2-cycle spacing, then stays low for 10 cycles → exactly one enter event, and the press pulse lands 6 cycles after the final falling edge.
- Invalid digit and limit:
  - digit = 4'hC with enter → no change.
  - A fourth valid digit after 1, 2, 3 → ignored; value stays 123.
- Simultaneous events: clear and enter pulses in the same cycle, entering 7 → value 0, digit_count 0. Done and enter in the same cycle while in ENTRY with value 12 → value_valid with value 12, state DONE.
- Reset mid-entry: after digits 4, 2, assert reset for 1 cycle → all outputs 0. Key held low through reset yields an event only after 4 further stable cycles.
